// File: rtl/serial_link_pkg.sv
// Shared types and sizing helpers for the serial shift link.
package serial_link_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, OVER} rx_state_e;

  localparam int SEG_FRAME_W = 64;  // 8 digits x 8 segments
  localparam int LED_FRAME_W = 16;  // LED chain

  // bit_cnt must hold 0..WIDTH+1 (WIDTH+1 marks an over-length frame)
  function automatic int cnt_w(input int width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser for one asynchronous input, plus a rise detector
// comparing the last stage against one extra delay flop.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   dly;

  // synchroniser chain and edge-delay flop
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync <= '0;
      dly  <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], d};
      dly  <= sync[SYNC_STAGES-1];
    end
  end

  assign level = sync[SYNC_STAGES-1];
  assign rise  = level & ~dly;

endmodule

// File: rtl/serial_shift_rx.sv
// Receiver for the clocked serial shift-out link: rebuilds the parallel
// frame in the clk domain and flags frames whose bit count != WIDTH.
module serial_shift_rx
  import serial_link_pkg::*;
#(
  parameter int WIDTH       = SEG_FRAME_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        ser_clk,
  input  logic                        ser_din,
  input  logic                        ser_pen,
  input  logic                        ser_clrn,
  output logic [WIDTH-1:0]            par_data,
  output logic                        par_valid,
  output logic                        frame_err,
  output logic [cnt_w(WIDTH)-1:0]     bit_cnt
);

  localparam int            CW       = cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_OVER = CW'(WIDTH + 1);

  logic clk_lvl, clk_rise, din_lvl, din_rise;
  logic pen_lvl, pen_rise, clrn_lvl, clrn_rise;

  // din shares the clock's depth so the sampled bit lines up with the rise
  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
    .clk(clk), .rstn(rstn), .d(ser_clk),  .level(clk_lvl),  .rise(clk_rise));
  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_din (
    .clk(clk), .rstn(rstn), .d(ser_din),  .level(din_lvl),  .rise(din_rise));
  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_pen (
    .clk(clk), .rstn(rstn), .d(ser_pen),  .level(pen_lvl),  .rise(pen_rise));
  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clrn (
    .clk(clk), .rstn(rstn), .d(ser_clrn), .level(clrn_lvl), .rise(clrn_rise));

  logic unused_sync;
  assign unused_sync = clk_lvl ^ din_rise ^ pen_lvl ^ clrn_rise;

  rx_state_e        state, state_nxt;
  logic [WIDTH-1:0] shift_reg, shift_nxt, par_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic             pv_nxt, fe_nxt;

  // state, shift register and output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      shift_reg <= '0;
      par_data  <= '0;
      bit_cnt   <= '0;
      par_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      shift_reg <= shift_nxt;
      par_data  <= par_nxt;
      bit_cnt   <= cnt_nxt;
      par_valid <= pv_nxt;
      frame_err <= fe_nxt;
    end
  end

  // next state: shift first, then the latch-enable check sees the post-shift view
  always_comb begin
    state_nxt = state;
    shift_nxt = shift_reg;
    par_nxt   = par_data;
    cnt_nxt   = bit_cnt;
    pv_nxt    = 1'b0;
    fe_nxt    = 1'b0;
    if (!clrn_lvl) begin
      state_nxt = IDLE;
      shift_nxt = '0;
      par_nxt   = '0;
      cnt_nxt   = '0;
    end else begin
      if (clk_rise) begin
        shift_nxt = {shift_reg[WIDTH-2:0], din_lvl};
        if (bit_cnt != CNT_OVER) cnt_nxt = bit_cnt + 1'b1;
        case (state)
          IDLE:    state_nxt = SHIFT;
          SHIFT:   if (cnt_nxt == CNT_OVER) state_nxt = OVER;
          default: state_nxt = OVER;
        endcase
      end
      if (pen_rise) begin
        if (cnt_nxt == CNT_FULL) begin
          par_nxt = shift_nxt;
          pv_nxt  = 1'b1;
        end else begin
          fe_nxt  = 1'b1;
        end
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    end
  end

endmodule

// File: doc/serial_shift_rx.md
Name: serial_shift_rx

Overview:
- Receiving end of the clocked serial shift-out link that drives the 7-segment and LED boards (serial clock, serial data, latch enable PEN, clear clrn).
- Captures the serial stream back into a parallel word in the system clock domain.
- Used as an on-chip loopback monitor and as a board-model receiver in system benches.
- Flags frames whose bit count does not match WIDTH.

Parameters:
WIDTH, 64, frame length in bits (64 = 8 digits x 8 segments; 16 for the LED chain)
SYNC_STAGES, 2, flip-flop stages on each asynchronous serial input (min 2)

Ports:
clk  input  1  system clock (clk_100mhz domain)
rstn  input  1  reset, asynchronous assert, active-low
ser_clk  input  1  serial shift clock from transmitter, asynchronous to clk
ser_din  input  1  serial data, sampled on ser_clk rising edge, MSB first
ser_pen  input  1  latch enable; rising edge ends the frame
ser_clrn  input  1  active-low clear from transmitter
par_data  output  WIDTH  last correctly received frame
par_valid  output  1  one-clk pulse when par_data updates
frame_err  output  1  one-clk pulse when a frame is closed with bit count != WIDTH
bit_cnt  output  clog2(WIDTH+2)  bits shifted in the current frame, saturating at WIDTH+1

Behaviour:
- Reset (rstn low, async): shift register, par_data, bit_cnt = 0; par_valid, frame_err = 0; FSM = IDLE; synchroniser flops = 0.
- Each of ser_clk, ser_din, ser_pen, ser_clrn passes through SYNC_STAGES flops. Edges are detected from the last stage vs one extra delay flop.
- ser_din uses the same depth as ser_clk, so data is sampled aligned with the clock edge.
- Transmitter contract: ser_clk high and low each >= SYNC_STAGES+1 clk periods; ser_din stable across the ser_clk rise.
- On a synced ser_clk rise: shift_reg <= {shift_reg[WIDTH-2:0], din_s}. bit_cnt increments, saturating at WIDTH+1.
- FSM states:
  - IDLE: bit_cnt = 0. A ser_clk rise moves to SHIFT.
  - SHIFT: 0 < bit_cnt <= WIDTH. A ser_clk rise that takes bit_cnt to WIDTH+1 moves to OVER.
  - OVER: further ser_clk rises keep shifting (last WIDTH bits retained); bit_cnt stays at WIDTH+1.
- On a synced ser_pen rise, in any state:
  - If bit_cnt == WIDTH: par_data <= shift_reg; par_valid = 1 for exactly one cycle.
  - Otherwise, including 0 and WIDTH+1: frame_err = 1 for one cycle; par_data unchanged.
  - In both cases, next cycle: bit_cnt = 0, FSM = IDLE. shift_reg is not cleared.
- Simultaneous ser_clk rise and ser_pen rise in the same clk cycle: the shift is applied first. The count check and latch use the post-shift register and count.
- Latency: ser_pen pin rise to par_valid high = SYNC_STAGES+1 clk cycles.
- Synced ser_clrn low (level): shift_reg, par_data, bit_cnt = 0; FSM = IDLE.
  - Edges seen while ser_clrn is low are ignored.
  - No par_valid or frame_err is produced while ser_clrn is low.
- rstn asserted mid-frame clears everything immediately; the partial frame is lost, with no error pulse.
- par_valid and frame_err are never high in the same cycle.

Decomposition:
- Shared package serial_link_pkg:
  - FSM state enum {IDLE, SHIFT, OVER}.
  - Default frame widths: SEG_FRAME_W = 64, LED_FRAME_W = 16.
  - Function for the bit_cnt width.
- One sub-module, sync_edge_det:
  - Parameterised SYNC_STAGES synchroniser plus rise detector.
  - Outputs the synced level and a rise pulse.
  - Instantiated four times: clk, din, pen, clrn.
- Top holds the FSM, shift register and output registers.

Test Plan:
- Reset release, then WIDTH=64 frame 0x0123_4567_89AB_CDEF MSB first, ser_clk half-period 4 clk, then pen rise -> par_valid pulses once, 3 clk after pen; par_data = 0x0123456789ABCDEF; frame_err stays 0.
- WIDTH=16: 15 bits, then pen -> frame_err pulse; par_data keeps previous value 0xA5A5. Next frame 0x5A5A (16 bits) -> par_valid; par_data = 0x5A5A.
- WIDTH=16: 18 bits (0b11 followed by 0xBEEF), then pen -> bit_cnt saturated at 17, frame_err pulse; a following good frame still latches correctly.
- Last ser_clk rise and pen rise on the same clk edge, completing bit 16 of 0x8001 -> par_valid; par_data = 0x8001.
- ser_clrn low for 10 clk mid-frame with ser_clk toggling -> par_data = 0, bit_cnt = 0, no pulses. After release, a full frame 0x1234 latches.
- rstn asserted asynchronously mid-frame, between clk edges -> outputs clear without waiting for a clk edge; no par_valid when the aborted frame's pen later arrives (frame_err only).
